// File: rtl/bird_physics.sv
// bird_physics: vertical motion and life-cycle FSM for the bird sprite.
//
// The bird idles at the spawn row until a start or flap launches it. While
// flying, each frame tick moves it by its velocity and then updates the
// velocity: either a flap kick or gravity, clamped at terminal velocity. A
// hit, or reaching the ground row, kills it. A start in DEAD returns to IDLE.
//
// Build option:
//   FLAP_EDGE_EN  defined   -> a flap is a 0->1 transition of flap_i, so
//                              holding the button yields one flap.
//                 undefined -> a flap is flap_i high on any clock, so holding
//                              the button re-flaps on every tick.
//
// Ports:
//   clock_i     system clock, rising edge
//   reset_L_i   asynchronous active-low reset
//   tick_i      one-clock frame strobe; physics advances only on tick
//   flap_i      synchronized flap button
//   start_i     one-clock start/restart request
//   hit_i       collision flag from the pipe checks
//   bird_y_o    current row, 0 = top of screen
//   bird_vel_o  current signed velocity (positive = downward)
//   alive_o     high in FLY
//   dead_o      high in DEAD
//   state_o     IDLE=00, FLY=01, DEAD=10

module bird_physics #(
   parameter int unsigned PW       = 10,
   parameter int unsigned VW       = 6,
   parameter int unsigned START_Y  = 240,
   parameter int unsigned GROUND   = 440,
   parameter int          FLAP_VEL = -8,
   parameter int unsigned GRAVITY  = 1,
   parameter int unsigned VMAX     = 8
) (
   input  logic          clock_i,
   input  logic          reset_L_i,
   input  logic          tick_i,
   input  logic          flap_i,
   input  logic          start_i,
   input  logic          hit_i,
   output logic [PW-1:0] bird_y_o,
   output logic [VW-1:0] bird_vel_o,
   output logic          alive_o,
   output logic          dead_o,
   output logic [1:0]    state_o
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StFly  = 2'b01,
      StDead = 2'b10
   } state_e;

   localparam logic        [PW-1:0] StartY  = PW'(START_Y);
   localparam logic        [PW-1:0] GroundY = PW'(GROUND);
   localparam logic signed [PW:0]   GroundS = (PW+1)'(GROUND);
   localparam logic signed [VW-1:0] FlapVel = VW'(FLAP_VEL);
   localparam logic signed [VW:0]   Grav    = (VW+1)'(GRAVITY);
   localparam logic signed [VW:0]   VmaxW   = (VW+1)'(VMAX);
   localparam logic signed [VW-1:0] VmaxV   = VW'(VMAX);

   state_e                 state_q, state_d;
   logic        [PW-1:0]   y_q, y_d;
   logic signed [VW-1:0]   vel_q, vel_d;
   logic                   pend_q, pend_d;
   logic                   flap_evt;

`ifdef FLAP_EDGE_EN
   logic flap_prev_q;

   always_ff @(posedge clock_i or negedge reset_L_i) begin
      if (!reset_L_i) begin
         flap_prev_q <= 1'b0;
      end else begin
         flap_prev_q <= flap_i;
      end
   end

   assign flap_evt = flap_i & ~flap_prev_q;
`else
   assign flap_evt = flap_i;
`endif

   // One bit of headroom plus sign so a move past the top goes negative and a
   // move past the bottom cannot wrap back into range.
   logic signed [PW:0] y_sum;
   assign y_sum = $signed({1'b0, y_q}) + $signed({{(PW+1-VW){vel_q[VW-1]}}, vel_q});

   // Gravity step computed one bit wider so VMAX near the top of the range
   // cannot overflow before the clamp.
   logic signed [VW:0]   vel_inc;
   logic signed [VW-1:0] vel_grav;
   assign vel_inc  = $signed({vel_q[VW-1], vel_q}) + Grav;
   assign vel_grav = (vel_inc > VmaxW) ? VmaxV : vel_inc[VW-1:0];

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      vel_d   = vel_q;
      pend_d  = pend_q;
      unique case (state_q)
         StIdle: begin
            y_d    = StartY;
            vel_d  = '0;
            pend_d = 1'b0;
            if (start_i || flap_evt) begin
               state_d = StFly;
               vel_d   = FlapVel;
            end
         end
         StFly: begin
            if (hit_i) begin
               // Hit beats a same-cycle tick: freeze where we are.
               state_d = StDead;
               vel_d   = '0;
               pend_d  = 1'b0;
            end else if (tick_i) begin
               pend_d = 1'b0;
               if (y_sum >= GroundS) begin
                  state_d = StDead;
                  y_d     = GroundY;
                  vel_d   = '0;
               end else begin
                  y_d   = y_sum[PW] ? '0 : y_sum[PW-1:0];
                  vel_d = (pend_q || flap_evt) ? FlapVel : vel_grav;
               end
            end else begin
               pend_d = pend_q | flap_evt;
            end
         end
         StDead: begin
            vel_d  = '0;
            pend_d = 1'b0;
            if (start_i) begin
               state_d = StIdle;
               y_d     = StartY;
            end
         end
         default: begin
            state_d = StIdle;
            y_d     = StartY;
            vel_d   = '0;
            pend_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_L_i) begin
      if (!reset_L_i) begin
         state_q <= StIdle;
         y_q     <= StartY;
         vel_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         vel_q   <= vel_d;
         pend_q  <= pend_d;
      end
   end

   assign bird_y_o   = y_q;
   assign bird_vel_o = vel_q;
   assign state_o    = state_q;
   assign alive_o    = (state_q == StFly);
   assign dead_o     = (state_q == StDead);

endmodule

// File: tb/tb_bird_physics.sv
// tb_bird_physics: directed stimulus for bird_physics with a queue-based
// scoreboard. Stimulus pushes the expected state and signals the monitor,
// which pops and compares against the DUT outputs. Expectations follow the
// FLAP_EDGE_EN setting of the build.

module tb_bird_physics;

   logic       clock;
   logic       reset_L;
   logic       tick;
   logic       flap;
   logic       start;
   logic       hit;
   logic [9:0] bird_y;
   logic [5:0] bird_vel;
   logic       alive;
   logic       dead;
   logic [1:0] state;

   bird_physics dut (
      .clock_i   (clock),
      .reset_L_i (reset_L),
      .tick_i    (tick),
      .flap_i    (flap),
      .start_i   (start),
      .hit_i     (hit),
      .bird_y_o  (bird_y),
      .bird_vel_o(bird_vel),
      .alive_o   (alive),
      .dead_o    (dead),
      .state_o   (state)
   );

   typedef struct {
      string name;
      int    y;
      int    vel;
      int    st;
   } exp_t;

   exp_t exp_q[$];
   event chk_ev;
   int   checks = 0;
   int   errors = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Monitor: pops every pending expectation whenever stimulus presents one.
   initial begin
      exp_t e;
      logic exp_alive;
      logic exp_dead;
      forever begin
         @(chk_ev);
         while (exp_q.size() > 0) begin
            e         = exp_q.pop_front();
            exp_alive = (e.st == 1);
            exp_dead  = (e.st == 2);
            checks++;
            if (bird_y !== 10'(e.y) || bird_vel !== 6'(e.vel) || state !== 2'(e.st) ||
                alive !== exp_alive || dead !== exp_dead) begin
               errors++;
               $display("FAIL %s: got y=%0d vel=%0d state=%b alive=%b dead=%b, want y=%0d vel=%0d state=%0d alive=%b dead=%b",
                        e.name, bird_y, $signed(bird_vel), state, alive, dead,
                        e.y, e.vel, e.st, exp_alive, exp_dead);
            end
         end
      end
   end

   task automatic expect_st(input string n, input int y, input int v, input int st);
      exp_t e;
      e.name = n;
      e.y    = y;
      e.vel  = v;
      e.st   = st;
      exp_q.push_back(e);
      -> chk_ev;
      #1;
   endtask

   // One clock with the given inputs held across the active edge.
   task automatic cyc(input logic t, input logic f, input logic s, input logic h);
      tick  = t;
      flap  = f;
      start = s;
      hit   = h;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tick    = 1'b0;
      flap    = 1'b0;
      start   = 1'b0;
      hit     = 1'b0;
      reset_L = 1'b1;
      #2 reset_L = 1'b0;
      #1;
      expect_st("reset", 240, 0, 0);
      repeat (2) @(posedge clock);
      #1 reset_L = 1'b1;
      cyc(0, 0, 0, 0);
      expect_st("idle_hold", 240, 0, 0);

      cyc(0, 0, 1, 0);
      expect_st("start", 240, -8, 1);

      // Full flight from launch to the ground, no flaps.
      for (int k = 1; k <= 42; k++) begin
         cyc(1, 0, 0, 0);
         case (k)
            1:  expect_st("tick1", 232, -7, 1);
            2:  expect_st("tick2", 225, -6, 1);
            8:  expect_st("apex", 204, 0, 1);
            16: expect_st("reach_vmax", 232, 8, 1);
            17: expect_st("vmax_clamp", 240, 8, 1);
            37: expect_st("fall_400", 400, 8, 1);
            38: expect_st("fall_408", 408, 8, 1);
            41: expect_st("fall_432", 432, 8, 1);
            42: expect_st("ground", 440, 0, 2);
            default: ;
         endcase
         cyc(0, 0, 0, 0);
         if (k == 1) expect_st("hold_between_ticks", 232, -7, 1);
         if (k == 2) begin
            cyc(0, 0, 1, 0);
            expect_st("start_in_fly", 225, -6, 1);
         end
      end

      cyc(1, 1, 0, 0);
      expect_st("dead_ignores", 440, 0, 2);
      cyc(0, 0, 1, 0);
      expect_st("dead_to_idle", 240, 0, 0);

      cyc(0, 1, 0, 0);
      expect_st("flap_launch", 240, -8, 1);
      cyc(1, 0, 0, 1);
      expect_st("hit_beats_tick", 240, 0, 2);
      cyc(0, 0, 1, 0);
      expect_st("restart_idle", 240, 0, 0);
      cyc(0, 0, 1, 0);
      expect_st("relaunch", 240, -8, 1);

      // Climb with a flap on each tick cycle, then hit the ceiling.
      for (int k = 0; k < 29; k++) begin
         cyc(1, 1, 0, 0);
         cyc(0, 0, 0, 0);
      end
      expect_st("climb", 8, -8, 1);
      cyc(1, 0, 0, 0);
      expect_st("ceiling_exact", 0, -7, 1);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      expect_st("ceiling_clamp", 0, -6, 1);

      // Flap between ticks is held pending and consumed by the next tick.
      cyc(0, 1, 0, 0);
      expect_st("pending_hold", 0, -6, 1);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      expect_st("pending_flap", 0, -8, 1);

      for (int k = 0; k < 8; k++) begin
         cyc(1, 0, 0, 0);
         cyc(0, 0, 0, 0);
      end
      expect_st("vel_zero", 0, 0, 1);

      // Flap held high across three ticks.
      cyc(1, 1, 0, 0);
      expect_st("held_flap1", 0, -8, 1);
      cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
`ifdef FLAP_EDGE_EN
      expect_st("held_flap2", 0, -7, 1);
`else
      expect_st("held_flap2", 0, -8, 1);
`endif
      cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
`ifdef FLAP_EDGE_EN
      expect_st("held_flap3", 0, -6, 1);
`else
      expect_st("held_flap3", 0, -8, 1);
`endif
      cyc(0, 0, 0, 0);

      // Asynchronous reset mid-flight, between clock edges.
      @(negedge clock);
      reset_L = 1'b0;
      #1;
      expect_st("async_reset", 240, 0, 0);
      reset_L = 1'b1;
      cyc(0, 0, 0, 0);
      expect_st("post_reset_idle", 240, 0, 0);
      cyc(0, 0, 1, 0);
      expect_st("post_reset_start", 240, -8, 1);

      #2;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
